// File: rtl/mem_port_arbiter.sv
// Shares one request/grant memory port between instruction fetch and data load/store.
// Data wins by default; fetch is forced through after STARVE_LIMIT data grants, and an owner FIFO routes responses.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 if_req_i,
    input  logic [XLEN-1:0]                      if_addr_i,
    output logic                                 if_gnt_o,
    output logic                                 if_rvalid_o,
    output logic [XLEN-1:0]                      if_rdata_o,
    input  logic                                 dm_req_i,
    input  logic                                 dm_we_i,
    input  logic [3:0]                           dm_be_i,
    input  logic [XLEN-1:0]                      dm_addr_i,
    input  logic [XLEN-1:0]                      dm_wdata_i,
    output logic                                 dm_gnt_o,
    output logic                                 dm_rvalid_o,
    output logic [XLEN-1:0]                      dm_rdata_o,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [3:0]                           mem_be_o,
    output logic [XLEN-1:0]                      mem_addr_o,
    output logic [XLEN-1:0]                      mem_wdata_o,
    input  logic                                 mem_gnt_i,
    input  logic                                 mem_rvalid_i,
    input  logic [XLEN-1:0]                      mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {IDLE, LOCKED} state_t;

    state_t          state_reg, state_next;
    logic            lock_owner_reg, lock_owner_next;
    logic            fifo_reg [MAX_OUTSTANDING];   // 0 = fetch, 1 = data
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [SW-1:0]   starve_reg;
    logic            err_reg;

    logic req, owner, full, empty, grant, push, pop, head;

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign head  = fifo_reg[rd_ptr_reg];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            lock_owner_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lock_owner_reg <= lock_owner_next;
        end
    end

    // Arbitration and lock decision; a stalled request keeps its owner until accepted.
    always_comb begin
        req             = 1'b0;
        owner           = 1'b0;
        state_next      = IDLE;
        lock_owner_next = lock_owner_reg;
        if (state_reg == LOCKED) begin
            req   = 1'b1;
            owner = lock_owner_reg;
        end else if (!full) begin
            if (dm_req_i && (!if_req_i || starve_reg < STARVE_MAX)) begin
                req   = 1'b1;
                owner = 1'b1;
            end else if (if_req_i) begin
                req   = 1'b1;
                owner = 1'b0;
            end
        end
        if (req && !mem_gnt_i) begin
            state_next      = LOCKED;
            lock_owner_next = owner;
        end
    end

    // Everything is forced to zero while reset is held, including pass-through paths.
    always_comb begin
        mem_req_o     = req & rst_ni;
        grant         = mem_req_o & mem_gnt_i;
        push          = grant;
        pop           = mem_rvalid_i & rst_ni & ~empty;
        mem_we_o      = mem_req_o & owner & dm_we_i;
        mem_be_o      = !mem_req_o ? 4'h0 : (owner ? dm_be_i : 4'hF);
        mem_addr_o    = !mem_req_o ? '0 : (owner ? dm_addr_i : if_addr_i);
        mem_wdata_o   = (mem_req_o && owner) ? dm_wdata_i : '0;
        if_gnt_o      = grant & ~owner;
        dm_gnt_o      = grant & owner;
        if_rvalid_o   = pop & ~head;
        dm_rvalid_o   = pop & head;
        if_rdata_o    = rst_ni ? mem_rdata_i : '0;
        dm_rdata_o    = rst_ni ? mem_rdata_i : '0;
        outstanding_o = count_reg;
        err_o         = err_reg;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_reg[i] <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (push) begin
                fifo_reg[wr_ptr_reg] <= owner;
                wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
            end
            if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push && pop) count_reg <= count_reg - 1'b1;

            if ((grant && !owner) || !if_req_i)
                starve_reg <= '0;
            else if (grant && owner && starve_reg != STARVE_MAX)
                starve_reg <= starve_reg + 1'b1;

            if (mem_rvalid_i && empty) err_reg <= 1'b1;
        end
    end
endmodule
